// File: rtl/instr_stream_encoder.sv
// Packs instruction requests into RV32I words and writes them sequentially into
// instruction memory; one word per three cycles, stops accepting once memory is full.
module instr_stream_encoder #(
    parameter int unsigned ADDR_W    = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_type,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {StIdle, StEnc, StWr} state_e;

    localparam logic [2:0] ClsR       = 3'd0;
    localparam logic [2:0] ClsLoad    = 3'd1;
    localparam logic [2:0] ClsStore   = 3'd2;
    localparam logic [2:0] ClsBranch  = 3'd3;
    localparam logic [2:0] ClsAluImm  = 3'd4;
    localparam logic [2:0] ClsJalr    = 3'd5;
    localparam logic [2:0] ClsJal     = 3'd6;
    localparam logic [2:0] ClsIllegal = 3'd7;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpAluImm = 7'b0010011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [ADDR_W:0] Depth = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [2:0]        type_q, type_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        rs1_q, rs1_d;
    logic [4:0]        rs2_q, rs2_d;
    logic [2:0]        f3_q, f3_d;
    logic              f7b5_q, f7b5_d;
    logic [20:0]       imm_q, imm_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic [31:0]       enc_word;

    // No encoding reaches above imm[20]; the upper bits are intentionally dropped.
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_imm[31:21];

    always_comb begin
        enc_word = '0;
        case (type_q)
            ClsR: begin
                enc_word = {1'b0, f7b5_q, 5'b0, rs2_q, rs1_q, f3_q, rd_q, OpR};
            end
            ClsLoad: begin
                enc_word = {imm_q[11:0], rs1_q, 3'b010, rd_q, OpLoad};
            end
            ClsStore: begin
                enc_word = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], OpStore};
            end
            ClsBranch: begin
                enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q,
                            imm_q[4:1], imm_q[11], OpBranch};
            end
            ClsAluImm: begin
                // Shift-immediates carry shamt in [24:20] and the arith/logic select in [30].
                if (f3_q == 3'b001 || f3_q == 3'b101) begin
                    enc_word = {1'b0, f7b5_q, 5'b0, imm_q[4:0], rs1_q, f3_q, rd_q, OpAluImm};
                end else begin
                    enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, OpAluImm};
                end
            end
            ClsJalr: begin
                enc_word = {imm_q[11:0], rs1_q, 3'b000, rd_q, OpJalr};
            end
            ClsJal: begin
                enc_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, OpJal};
            end
            default: begin
                enc_word = '0;
            end
        endcase
    end

    assign full = (count_q == Depth);

    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        f3_d     = f3_q;
        f7b5_d   = f7b5_q;
        imm_d    = imm_q;
        wdata_d  = wdata_q;
        ptr_d    = ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        in_ready = 1'b0;
        case (state_q)
            StIdle: begin
                in_ready = !full;
                if (in_valid && !full) begin
                    type_d  = in_type;
                    rd_d    = in_rd;
                    rs1_d   = in_rs1;
                    rs2_d   = in_rs2;
                    f3_d    = in_funct3;
                    f7b5_d  = in_funct7b5;
                    imm_d   = in_imm[20:0];
                    state_d = StEnc;
                end
            end
            StEnc: begin
                wdata_d = enc_word;
                if (type_q == ClsIllegal) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StWr;
                end
            end
            StWr: begin
                // ptr wraps to zero exactly when count reaches Depth, so nothing is overwritten.
                ptr_d   = ptr_q + 1'b1;
                count_d = count_q + 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            type_q  <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            f3_q    <= '0;
            f7b5_q  <= 1'b0;
            imm_q   <= '0;
            wdata_q <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            f3_q    <= f3_d;
            f7b5_q  <= f7b5_d;
            imm_q   <= imm_d;
            wdata_q <= wdata_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign imem_we    = (state_q == StWr);
    assign imem_addr  = BASE_ADDR + {{(30 - ADDR_W){1'b0}}, ptr_q, 2'b00};
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Self-checking bench for instr_stream_encoder: directed program-loader cases plus a
// randomized request stream scored against an arithmetic model of the encoding rules.
module tb_instr_stream_encoder;

    localparam int unsigned AW    = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_type;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [2:0]    in_funct3;
    logic          in_funct7b5;
    logic [31:0]   in_imm;
    logic          imem_we;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          full;
    logic          err;

    instr_stream_encoder #(
        .ADDR_W    (AW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_type     (in_type),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_funct3   (in_funct3),
        .in_funct7b5 (in_funct7b5),
        .in_imm      (in_imm),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .count       (count),
        .full        (full),
        .err         (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned m_count  = 0;
    bit          m_err    = 1'b0;
    bit          have_prev = 1'b0;
    int unsigned prev_cyc = 0;
    logic [31:0] last_wdata;
    logic [31:0] last_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference encoding built field by field with shifts and masks.
    function automatic logic [31:0] ref_enc(input int t, input int rd, input int rs1,
                                            input int rs2, input int f3, input int f7,
                                            input logic [31:0] imm);
        logic [31:0] r;
        logic [31:0] base_i;
        r = 32'(rd) << 7;
        base_i = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15);
        case (t)
            0: r = r | (32'(f7) << 30) | (32'(rs2) << 20) | (32'(rs1) << 15)
                     | (32'(f3) << 12) | 32'h33;
            1: r = r | base_i | (32'd2 << 12) | 32'h03;
            2: r = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                   | (32'd2 << 12) | ((imm & 32'h1F) << 7) | 32'h23;
            3: r = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                   | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                   | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
            4: begin
                if (f3 == 1 || f3 == 5)
                    r = r | (32'(f7) << 30) | ((imm & 32'h1F) << 20) | (32'(rs1) << 15)
                          | (32'(f3) << 12) | 32'h13;
                else
                    r = r | base_i | (32'(f3) << 12) | 32'h13;
            end
            5: r = r | base_i | 32'h67;
            6: r = r | (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                     | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | 32'h6F;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic scramble();
        in_type     = 3'($urandom);
        in_rd       = 5'($urandom);
        in_rs1      = 5'($urandom);
        in_rs2      = 5'($urandom);
        in_funct3   = 3'($urandom);
        in_funct7b5 = 1'($urandom);
        in_imm      = $urandom;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        m_count   = 0;
        m_err     = 1'b0;
        have_prev = 1'b0;
        check_eq("rst_we", imem_we, 0);
        check_eq("rst_addr", imem_addr, BASE);
        check_eq("rst_wdata", imem_wdata, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_full", full, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_ready", in_ready, 1);
    endtask

    // Called at a negedge with the encoder idle and not full; returns at the negedge of
    // the next idle cycle with in_valid still high, so a following call streams back-to-back.
    task automatic send(input int t, input int rd, input int rs1, input int rs2, input int f3,
                        input int f7, input logic [31:0] imm, input bit gap);
        logic [31:0] exp_w;
        exp_w       = ref_enc(t, rd, rs1, rs2, f3, f7, imm);
        in_type     = 3'(t);
        in_rd       = 5'(rd);
        in_rs1      = 5'(rs1);
        in_rs2      = 5'(rs2);
        in_funct3   = 3'(f3);
        in_funct7b5 = 1'(f7);
        in_imm      = imm;
        in_valid    = 1'b1;
        check_eq("idle_ready", in_ready, 1);
        @(negedge clk);
        check_eq("enc_ready", in_ready, 0);
        check_eq("enc_we", imem_we, 0);
        scramble();
        @(negedge clk);
        if (t == 7) begin
            m_err = 1'b1;
            check_eq("ill_we", imem_we, 0);
            check_eq("ill_count", count, m_count);
            check_eq("ill_err", err, 1);
            check_eq("ill_ready", in_ready, 1);
        end else begin
            check_eq("wr_we", imem_we, 1);
            check_eq("wr_addr", imem_addr, BASE + 32'(4 * m_count));
            check_eq("wr_data", imem_wdata, exp_w);
            check_eq("wr_ready", in_ready, 0);
            last_wdata = imem_wdata;
            last_addr  = imem_addr;
            if (gap && have_prev) check_eq("wr_gap", cyc - prev_cyc, 3);
            prev_cyc  = cyc;
            have_prev = 1'b1;
            m_count++;
            scramble();
            @(negedge clk);
            check_eq("post_we", imem_we, 0);
            check_eq("post_count", count, m_count);
            check_eq("post_full", full, (m_count == DEPTH) ? 1 : 0);
            check_eq("post_err", err, m_err);
            check_eq("post_ready", in_ready, (m_count < DEPTH) ? 1 : 0);
        end
    endtask

    task automatic reject_test();
        scramble();
        in_type  = 3'd0;
        in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_eq("full_ready", in_ready, 0);
            check_eq("full_we", imem_we, 0);
            check_eq("full_flag", full, 1);
            check_eq("full_count", count, DEPTH);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        scramble();
        do_reset();

        send(0, 3, 1, 2, 0, 0, 32'd0, 1'b0);
        check_eq("add_word", last_wdata, 32'h002081B3);
        check_eq("add_addr", last_addr, 32'h0);

        do_reset();
        send(1, 5, 2, 0, 0, 0, 32'd8, 1'b1);
        check_eq("lw_word", last_wdata, 32'h00812283);
        send(2, 0, 2, 5, 0, 0, 32'd12, 1'b1);
        check_eq("sw_word", last_wdata, 32'h00512623);
        check_eq("sw_addr", last_addr, 32'h4);
        send(3, 0, 1, 2, 0, 0, 32'd8, 1'b1);
        check_eq("beq_word", last_wdata, 32'h00208463);
        send(6, 1, 0, 0, 0, 0, 32'd16, 1'b1);
        check_eq("jal_word", last_wdata, 32'h010000EF);
        check_eq("jal_addr", last_addr, 32'hC);
        reject_test();

        do_reset();
        send(7, 1, 2, 3, 0, 0, 32'd5, 1'b0);
        send(0, 3, 1, 2, 0, 0, 32'd0, 1'b0);
        check_eq("add2_addr", last_addr, BASE);
        send(4, 4, 4, 0, 5, 1, 32'd3, 1'b0);
        check_eq("srai_word", last_wdata, 32'h40325213);
        check_eq("srai_addr", last_addr, 32'h4);

        // Reset lands on the edge closing the WR cycle of a third word.
        in_type = 3'd0; in_rd = 5'd7; in_rs1 = 5'd1; in_rs2 = 5'd2;
        in_funct3 = 3'd0; in_funct7b5 = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("midwr_we", imem_we, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_count = 0; m_err = 1'b0; have_prev = 1'b0;
        check_eq("midrst_we", imem_we, 0);
        check_eq("midrst_count", count, 0);
        check_eq("midrst_err", err, 0);
        check_eq("midrst_ready", in_ready, 1);
        send(0, 9, 10, 11, 7, 0, 32'd0, 1'b0);
        check_eq("midrst_addr", last_addr, BASE);

        for (int i = 0; i < 80; i++) begin
            if (m_count == DEPTH) begin
                if ($urandom_range(0, 1) == 1) reject_test();
                do_reset();
            end else if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    check_eq("idle_we", imem_we, 0);
                end
            end else begin
                send($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 1),
                     $urandom, 1'b0);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_stream_encoder.md
Name: instr_stream_encoder

Overview:
- Writer-side counterpart of the opcode decoder: accepts instruction requests (class, register fields, funct, immediate) on a valid/ready handshake.
- Packs each request into a 32-bit RV32I word with the opcode the decoder expects.
- Writes the words sequentially into instruction memory.
- Used as the boot/program loader and as the stimulus source for processor-level tests.

Parameters:
- ADDR_W, 6, log2 of instruction-memory depth in words.
- BASE_ADDR, 32'h0000_0000, byte address of the first written word.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request
- in_type  in  3  instruction class: 0 R, 1 lw, 2 sw, 3 branch, 4 I-ALU, 5 jalr, 6 jal, 7 illegal
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3 field, used by R, branch and I-ALU
- in_funct7b5  in  1  instr[30] for R-type and shift-immediates
- in_imm  in  32  raw immediate, sign-extended byte offset
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  32  byte address = BASE_ADDR + 4*ptr
- imem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written since reset
- full  out  1  count == 2**ADDR_W
- err  out  1  sticky illegal-class flag

Behaviour:
- Reset is synchronous and active-high; single clock. The following reset values apply, including when reset is asserted mid-operation:
  - state=IDLE
  - ptr=0, count=0
  - full=0, err=0
  - imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0
- FSM has three states: IDLE, ENC, WR.
- IDLE:
  - in_ready = !full.
  - Handshake occurs when in_valid && in_ready at a clock edge. On handshake, all in_* fields are registered and the FSM moves to ENC.
- ENC:
  - in_ready=0.
  - The registered fields are encoded into imem_wdata.
  - For class 7 (illegal): err<=1, no write, return to IDLE with ptr/count unchanged.
  - For all other classes: go to WR.
- WR:
  - imem_we=1 for exactly this one cycle; imem_addr = BASE_ADDR + {ptr,2'b00}.
  - At the end of the cycle: ptr<=ptr+1, count<=count+1, go to IDLE.
- Timing:
  - Latency: imem_we is high in the second cycle after the handshake edge.
  - Peak throughput: one word per 3 cycles.
- Encoding (op = opcode):
  - R: {funct7b5?7'b0100000:7'b0, rs2, rs1, funct3, rd, 0110011}
  - lw: {imm[11:0], rs1, 010, rd, 0000011}
  - sw: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}
  - branch: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}
  - I-ALU: {imm[11:0], rs1, funct3, rd, 0010011}
    - Exception: when funct3 is 001 or 101, bits[31:25] = {1'b0, funct7b5, 5'b0} and bits[24:20] = imm[4:0].
  - jalr: {imm[11:0], rs1, 000, rd, 1100111}
  - jal: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}
- Immediate handling:
  - No range checking; out-of-range immediates are truncated to the listed bits.
  - imm[0] is ignored for branch and jal.
- Capacity and wrap-around:
  - When count reaches 2**ADDR_W, full=1 and in_ready=0 permanently until reset.
  - ptr (ADDR_W bits) wraps to 0 only at that point, so no overwrite occurs.
- Handshake edge cases:
  - in_valid held high while busy: no acceptance until the FSM is back in IDLE.
  - Fields changing during ENC/WR do not affect the word in flight.
- err is sticky: it stays 1 after further legal requests and clears only on reset.

Test Plan:
- Request add x3,x1,x2 (type 0, rd 3, rs1 1, rs2 2, f3 0, f7b5 0) after reset -> imem_we pulse at imem_addr 0x0, imem_wdata 0x002081B3, count=1.
- Back-to-back stream with in_valid held high:
  - lw x5,8(x2) -> 0x00812283 at 0x0
  - sw x5,12(x2) -> 0x00512623 at 0x4
  - beq x1,x2,+8 -> 0x00208463 at 0x8
  - jal x1,+16 -> 0x010000EF at 0xC
  - Required: each word written 3 cycles apart; in_ready low during ENC/WR.
- ADDR_W=2: write 4 legal words -> count=4, full=1, in_ready=0; a 5th request is never accepted and no imem_we occurs.
- type 7 request -> err=1, no imem_we, count unchanged; a following legal add is still written at the next address and err stays 1.
- Assert reset during the WR cycle -> next cycle imem_we=0, count=0, err=0, in_ready=1; the next request writes at BASE_ADDR.
- srai x4,x4,3 (type 4, f3 101, f7b5 1, imm 3) -> 0x40325213.
